// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, addresses the instruction ROM and
// registers the returned word into IF/ID, with stall, redirect, EBREAK halt and fault handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [31:0]       rom_instruccion,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       fault_pc,
  output logic [31:0]       fetch_count
);

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        if_valid_nxt;
  logic [31:0] if_pc_nxt, if_instr_nxt;
  logic        halted_nxt, fault_nxt;
  logic [31:0] fault_pc_nxt, fetch_count_nxt;

  // Any address bit above the ROM span makes the byte address unreachable (no aliasing).
  function automatic logic in_rom(input logic [31:0] addr);
    return (addr >> (ADDR_W + 2)) == 32'd0;
  endfunction

  assign rom_address = pc[ADDR_W+1:2];

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_nxt       = state;
    pc_nxt          = pc;
    if_valid_nxt    = if_valid;
    if_pc_nxt       = if_pc;
    if_instr_nxt    = if_instr;
    halted_nxt      = halted;
    fault_nxt       = fault;
    fault_pc_nxt    = fault_pc;
    fetch_count_nxt = fetch_count;

    unique case (state)
      BOOT: begin
        state_nxt = RUN;
      end

      RUN: begin
        if (redirect_valid) begin
          if_valid_nxt = 1'b0;
          if (redirect_pc[1:0] != 2'b00 || !in_rom(redirect_pc)) begin
            state_nxt    = FAULT;
            fault_nxt    = 1'b1;
            fault_pc_nxt = redirect_pc;
          end else begin
            pc_nxt = redirect_pc;
          end
        end else if (!stall) begin
          if (!in_rom(pc)) begin
            state_nxt    = FAULT;
            fault_nxt    = 1'b1;
            fault_pc_nxt = pc;
            if_valid_nxt = 1'b0;
          end else begin
            if_instr_nxt    = rom_instruccion;
            if_pc_nxt       = pc;
            if_valid_nxt    = 1'b1;
            fetch_count_nxt = fetch_count + 32'd1;
            // The EBREAK itself is handed to decode; pc then stays on it.
            if (rom_instruccion == EBREAK) begin
              state_nxt  = HALT;
              halted_nxt = 1'b1;
            end else begin
              pc_nxt = pc + 32'd4;
            end
          end
        end
      end

      HALT: begin
        if (!stall) if_valid_nxt = 1'b0;
      end

      FAULT: begin
        if_valid_nxt = 1'b0;
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RST) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= 32'd0;
      if_instr    <= NOP;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_pc    <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_valid    <= if_valid_nxt;
      if_pc       <= if_pc_nxt;
      if_instr    <= if_instr_nxt;
      halted      <= halted_nxt;
      fault       <= fault_nxt;
      fault_pc    <= fault_pc_nxt;
      fetch_count <= fetch_count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences, and
// randomized traffic checked against a transaction-level fetch model.
module tb_fetch_unit;

  localparam int          ADDR_W    = 10;
  localparam int          ROM_WORDS = 1 << ADDR_W;
  localparam logic [31:0] ROM_BYTES = 32'h0000_1000;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  logic              CLK = 1'b0;
  logic              RST;
  logic [ADDR_W-1:0] rom_address;
  logic [31:0]       rom_instruccion;
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              if_valid;
  logic [31:0]       if_pc;
  logic [31:0]       if_instr;
  logic              halted;
  logic              fault;
  logic [31:0]       fault_pc;
  logic [31:0]       fetch_count;

  logic [31:0] rom [ROM_WORDS];

  always #5 CLK = ~CLK;

  assign rom_instruccion = rom[rom_address];

  fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .rom_address    (rom_address),
    .rom_instruccion(rom_instruccion),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .halted         (halted),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rword(input int i);
    return NOP + 32'(i << 7);
  endfunction

  task automatic fill_default_rom();
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = rword(i);
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, return at the next falling edge.
  task automatic tick(input logic rst, input logic st, input logic rv, input logic [31:0] rpc);
    RST            = rst;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".if_valid"},    32'(if_valid),    32'd0);
    check({tag, ".if_pc"},       if_pc,            32'd0);
    check({tag, ".if_instr"},    if_instr,         NOP);
    check({tag, ".halted"},      32'(halted),      32'd0);
    check({tag, ".fault"},       32'(fault),       32'd0);
    check({tag, ".fault_pc"},    fault_pc,         32'd0);
    check({tag, ".fetch_count"}, fetch_count,      32'd0);
    check({tag, ".rom_address"}, 32'(rom_address), 32'd0);
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_count;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                              input logic [31:0] ecnt, input logic [31:0] eaddr);
    vec_t v;
    v.stall = st; v.rv = rv; v.rpc = rpc;
    v.e_valid = ev; v.e_pc = epc; v.e_instr = ein; v.e_count = ecnt; v.e_addr = eaddr;
    return v;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  logic        m_boot, m_halt, m_fault, m_valid;
  logic [31:0] m_pc, m_ifpc, m_instr, m_count, m_fpc;

  task automatic model_step(input logic rst, input logic st, input logic rv, input logic [31:0] rpc);
    logic [31:0] w;
    if (rst) begin
      m_pc = 32'd0; m_boot = 1'b1; m_halt = 1'b0; m_fault = 1'b0; m_valid = 1'b0;
      m_ifpc = 32'd0; m_instr = NOP; m_count = 32'd0; m_fpc = 32'd0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_fault) begin
      m_valid = 1'b0;
    end else if (m_halt) begin
      if (!st) m_valid = 1'b0;
    end else if (rv) begin
      m_valid = 1'b0;
      if ((rpc % 4) != 0 || rpc >= ROM_BYTES) begin
        m_fault = 1'b1; m_fpc = rpc;
      end else begin
        m_pc = rpc;
      end
    end else if (!st) begin
      if (m_pc >= ROM_BYTES) begin
        m_fault = 1'b1; m_fpc = m_pc; m_valid = 1'b0;
      end else begin
        w = rom[m_pc / 4];
        m_valid = 1'b1; m_ifpc = m_pc; m_instr = w; m_count = m_count + 1;
        if (w == EBREAK) m_halt = 1'b1;
        else m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic compare_model();
    check("rnd.if_valid",    32'(if_valid), 32'(m_valid));
    check("rnd.if_pc",       if_pc,         m_ifpc);
    check("rnd.if_instr",    if_instr,      m_instr);
    check("rnd.halted",      32'(halted),   32'(m_halt));
    check("rnd.fault",       32'(fault),    32'(m_fault));
    check("rnd.fault_pc",    fault_pc,      m_fpc);
    check("rnd.fetch_count", fetch_count,   m_count);
    if (!m_halt) check("rnd.rom_address", 32'(rom_address), (m_pc / 4) % ROM_WORDS);
  endtask

  vec_t vecs[11];

  initial begin
    RST = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    fill_default_rom();

    vecs[0]  = mk(0, 0, 32'h0,  0, 32'h00, NOP,       0, 0);
    vecs[1]  = mk(0, 0, 32'h0,  1, 32'h00, rword(0),  1, 1);
    vecs[2]  = mk(0, 0, 32'h0,  1, 32'h04, rword(1),  2, 2);
    vecs[3]  = mk(0, 0, 32'h0,  1, 32'h08, rword(2),  3, 3);
    vecs[4]  = mk(1, 0, 32'h0,  1, 32'h08, rword(2),  3, 3);
    vecs[5]  = mk(1, 0, 32'h0,  1, 32'h08, rword(2),  3, 3);
    vecs[6]  = mk(1, 0, 32'h0,  1, 32'h08, rword(2),  3, 3);
    vecs[7]  = mk(0, 0, 32'h0,  1, 32'h0C, rword(3),  4, 4);
    vecs[8]  = mk(1, 1, 32'h40, 0, 32'h0C, rword(3),  4, 16);
    vecs[9]  = mk(0, 0, 32'h0,  1, 32'h40, rword(16), 5, 17);
    vecs[10] = mk(0, 0, 32'h0,  1, 32'h44, rword(17), 6, 18);

    @(negedge CLK);

    // Directed table: reset, boot cycle, sequential run, stall hold, redirect beating stall.
    tick(1, 0, 0, 0);
    check_reset_values("rst0");
    for (int i = 0; i < 11; i++) begin
      tick(0, vecs[i].stall, vecs[i].rv, vecs[i].rpc);
      check($sformatf("vec%0d.if_valid", i),    32'(if_valid),    32'(vecs[i].e_valid));
      check($sformatf("vec%0d.if_pc", i),       if_pc,            vecs[i].e_pc);
      check($sformatf("vec%0d.if_instr", i),    if_instr,         vecs[i].e_instr);
      check($sformatf("vec%0d.fetch_count", i), fetch_count,      vecs[i].e_count);
      check($sformatf("vec%0d.rom_address", i), 32'(rom_address), vecs[i].e_addr);
    end

    // EBREAK at word 5: issued, held under stall, dropped when decode takes it, redirects ignored.
    rom[5] = EBREAK;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
    check("halt.if_valid",    32'(if_valid), 32'd1);
    check("halt.if_pc",       if_pc,         32'h14);
    check("halt.if_instr",    if_instr,      EBREAK);
    check("halt.halted",      32'(halted),   32'd1);
    check("halt.fetch_count", fetch_count,   32'd6);
    tick(0, 1, 0, 0);
    check("halt_stall.if_valid", 32'(if_valid), 32'd1);
    tick(0, 0, 0, 0);
    check("halt_drop.if_valid", 32'(if_valid), 32'd0);
    tick(0, 0, 1, 32'h0);
    tick(0, 0, 0, 0);
    check("halt_redir.if_valid",    32'(if_valid), 32'd0);
    check("halt_redir.if_pc",       if_pc,         32'h14);
    check("halt_redir.fetch_count", fetch_count,   32'd6);
    check("halt_redir.halted",      32'(halted),   32'd1);
    check("halt_redir.fault",       32'(fault),    32'd0);
    rom[5] = rword(5);

    // Misaligned redirect faults and freezes everything.
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 32'h22);
    check("mis.fault",       32'(fault),    32'd1);
    check("mis.fault_pc",    fault_pc,      32'h22);
    check("mis.if_valid",    32'(if_valid), 32'd0);
    check("mis.fetch_count", fetch_count,   32'd1);
    tick(0, 0, 1, 32'h40);
    tick(0, 0, 0, 0);
    check("mis_hold.fault_pc",    fault_pc,      32'h22);
    check("mis_hold.if_valid",    32'(if_valid), 32'd0);
    check("mis_hold.fetch_count", fetch_count,   32'd1);
    check("mis_hold.halted",      32'(halted),   32'd0);

    // Last ROM word issues; running past it faults without aliasing to word 0.
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 32'hFFC);
    check("end_redir.if_valid", 32'(if_valid), 32'd0);
    tick(0, 0, 0, 0);
    check("end_fetch.if_valid", 32'(if_valid), 32'd1);
    check("end_fetch.if_pc",    if_pc,         32'hFFC);
    check("end_fetch.if_instr", if_instr,      rword(ROM_WORDS - 1));
    check("end_fetch.fault",    32'(fault),    32'd0);
    tick(0, 0, 0, 0);
    check("end_fault.fault",       32'(fault),    32'd1);
    check("end_fault.fault_pc",    fault_pc,      32'h1000);
    check("end_fault.if_valid",    32'(if_valid), 32'd0);
    check("end_fault.fetch_count", fetch_count,   32'd1);

    // Reset while stalled mid-run.
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    check_reset_values("rst_mid");
    tick(0, 0, 0, 0);
    check("rst_boot.if_valid", 32'(if_valid), 32'd0);
    tick(0, 0, 0, 0);
    check("rst_resume.if_valid",    32'(if_valid), 32'd1);
    check("rst_resume.if_pc",       if_pc,         32'd0);
    check("rst_resume.if_instr",    if_instr,      rword(0));
    check("rst_resume.fetch_count", fetch_count,   32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < ROM_WORDS; i++)
      rom[i] = ($urandom_range(0, 47) == 0) ? EBREAK : $urandom;
    model_step(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    compare_model();
    for (int c = 0; c < 3000; c++) begin
      logic        rst, st, rv;
      logic [31:0] rpc;
      int          kind;
      rst  = ($urandom_range(0, 39) == 0);
      st   = ($urandom_range(0, 3) == 0);
      rv   = ($urandom_range(0, 7) == 0);
      kind = $urandom_range(0, 9);
      if (kind == 0)      rpc = (32'($urandom_range(0, ROM_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (kind == 1) rpc = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
      else if (kind == 2) rpc = 32'hFF0 + (32'($urandom_range(0, 3)) << 2);
      else                rpc = 32'($urandom_range(0, ROM_WORDS - 1)) << 2;
      model_step(rst, st, rv, rpc);
      tick(rst, st, rv, rpc);
      compare_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
